cache_mshr_file: RTL and testbench
==================================

// Module: cache_mshr_file
// PURPOSE
//   Miss-status holding register file directly downstream of the cache metadata next-state logic.
//   Takes mshr_alloc/way_out/is_evict/wb_to_l2 per lookup and tracks each outstanding miss.
//   Returns mshr_hit so a repeat miss to the same line neither re-allocates nor goes to L2.
//   Sequences victim writeback then line fetch to L2, and hands each L2 fill to the tag/data arrays.
// PARAMETERS
//   NUM_ENTRIES  4   outstanding misses tracked; power of two, >=2
//   LINE_AW      26  line-address width (byte address >> 6)
//   ID_W         2   entry id width, = clog2(NUM_ENTRIES)
// PORTS
//   clk            in   1        sole clock, rising edge
//   rst            in   1        synchronous, active-high reset
//   lookup_addr    in   LINE_AW  line address of current pipeline lookup
//   mshr_hit       out  1        comb: lookup_addr matches any non-IDLE entry
//   alloc_valid    in   1        mshr_alloc from metadata stage
//   alloc_addr     in   LINE_AW  missing line address
//   alloc_way      in   4        one-hot way_out for the fill
//   alloc_op       in   3        LD=1 / ST=2; other codes ignored
//   alloc_wb       in   1        victim dirty, writeback required
//   alloc_victim   in   LINE_AW  victim line address (valid when alloc_wb)
//   mshr_full      out  1        registered: every entry non-IDLE
//   l2_req_valid   out  1        request to L2
//   l2_req_ready   in   1        L2 accepts request
//   l2_req_addr    out  LINE_AW  line address
//   l2_req_wb      out  1        1 = writeback (no response), 0 = read
//   l2_req_id      out  ID_W     entry id
//   l2_resp_valid  in   1        L2 fill data returned
//   l2_resp_id     in   ID_W     entry the response belongs to
//   fill_valid     out  1        fill ready for tag/data arrays
//   fill_ready     in   1        arrays accept fill
//   fill_addr      out  LINE_AW  filled line address
//   fill_way       out  4        one-hot way
//   fill_op        out  3        original op (ST -> fill to M, LD -> S)
//   fill_id        out  ID_W     entry id
// BEHAVIOUR
//   Reset: all entries IDLE; mshr_full, l2_req_valid, fill_valid = 0; other outputs 0.
//   Per-entry FSM: IDLE -> (alloc, wb) WB_REQ | (alloc, !wb) RD_REQ; WB_REQ -> RD_REQ on accept;
//     RD_REQ -> WAIT on accept; WAIT -> FILL on l2_resp_valid && l2_resp_id==id; FILL -> IDLE on fill_ready.
//   Alloc accepted iff alloc_valid && !mshr_full && alloc_op in {LD,ST}; lowest-index IDLE entry.
//     Alloc while full is dropped (upstream must stall on mshr_full); assertion fires.
//     Entry captures addr/way/op/wb/victim; state visible (mshr_hit, full) next cycle.
//   mshr_hit: comb compare against registered entries only; the entry allocated this cycle does not hit.
//   Alloc to an addr already held by a live entry: illegal (upstream gates via mshr_hit); assertion.
//   L2 request: lowest-index entry in WB_REQ/RD_REQ drives l2_req_*; held stable while valid && !ready.
//     WB_REQ drives alloc_victim with l2_req_wb=1; RD_REQ drives alloc_addr with l2_req_wb=0.
//     Arbitration is frozen while a request is pending (no switching until accept).
//   Fill: lowest-index FILL entry drives fill_*; stable until fill_ready; 1-cycle min residency in FILL.
//   Entry freed by fill_ready is IDLE next cycle; cannot be reallocated in the same cycle it frees.
//   Simultaneous alloc, req accept, resp and fill on different entries: all take effect same cycle.
//   l2_resp_valid for an entry not in WAIT: ignored, assertion fires.
//   Latency: alloc -> l2_req_valid 1 cycle (no wb, req bus idle); resp -> fill_valid 1 cycle.
//   rst mid-operation discards all entries; in-flight L2 responses after reset are ignored.
// STRUCTURE
//   cache_pkg: op codes NO_OP..RWITM (0..7), MSHR state encodings (IDLE,WB_REQ,RD_REQ,WAIT,FILL).
//   Sub-module mshr_entry: one FSM + payload regs, instantiated NUM_ENTRIES times (generate).
//   Top: free-entry priority encoder, req and fill priority arbiters, mshr_hit compare OR-tree.
// TESTING
//   LD miss 0x100, way 4'b0010, no wb, ready=1 -> next cycle req addr 0x100 wb=0 id=0; resp id0 -> fill way 0010 op LD.
//   ST miss 0x200 wb=1 victim 0x3F0 -> req 0x3F0 wb=1, then req 0x200 wb=0, both id0; resp id0 -> fill op ST.
//   4 allocs, ready=0 -> mshr_full=1 after 4th; 5th alloc_valid dropped + assertion; lookup 0x100 -> mshr_hit=1.
//   l2_req_ready=0 for 5 cycles -> addr/id/wb stable throughout; accepted once, no duplicate request.
//   Out-of-order resp ids 2 then 0, fill_ready=0 for 3 cycles -> fill id2 held, then id0; entries IDLE after.
//   rst asserted with entries in WAIT and FILL -> next cycle all outputs 0, mshr_hit=0, later resp ignored.

Source files
------------

// File: rtl/cache_mshr_file_pkg.sv
// cache_mshr_file_pkg: shared sizes, op codes and MSHR entry state encodings
package cache_mshr_file_pkg;
  localparam int MSHR_N       = 4;
  localparam int MSHR_LINE_AW = 26;
  localparam int MSHR_ID_W    = 2;
  typedef enum logic [2:0] {OP_NO_OP, OP_LD, OP_ST, OP_IFETCH, OP_PF, OP_FLUSH, OP_INV, OP_RWITM} op_e;
  typedef enum logic [2:0] {S_IDLE, S_WB_REQ, S_RD_REQ, S_WAIT, S_FILL} mshr_state_e;
  function automatic logic is_alloc_op(logic [2:0] op);
    return op == OP_LD || op == OP_ST;
  endfunction
endpackage

// File: rtl/cache_mshr_file_if.sv
// cache_mshr_file_if: lookup/alloc in, L2 req/resp, fill out; master = cache pipeline + L2 + arrays, slave = MSHR file
interface cache_mshr_file_if import cache_mshr_file_pkg::*; #(
  parameter int LINE_AW = MSHR_LINE_AW,
  parameter int ID_W    = MSHR_ID_W
);
  logic [LINE_AW-1:0] lookup_addr, alloc_addr, alloc_victim, l2_req_addr, fill_addr;
  logic               mshr_hit, alloc_valid, alloc_wb, mshr_full;
  logic               l2_req_valid, l2_req_ready, l2_req_wb, l2_resp_valid, fill_valid, fill_ready;
  logic [3:0]         alloc_way, fill_way;
  logic [2:0]         alloc_op, fill_op;
  logic [ID_W-1:0]    l2_req_id, l2_resp_id, fill_id;
  modport master (
    output lookup_addr, alloc_valid, alloc_addr, alloc_way, alloc_op, alloc_wb, alloc_victim,
    output l2_req_ready, l2_resp_valid, l2_resp_id, fill_ready,
    input  mshr_hit, mshr_full, l2_req_valid, l2_req_addr, l2_req_wb, l2_req_id,
    input  fill_valid, fill_addr, fill_way, fill_op, fill_id
  );
  modport slave (
    input  lookup_addr, alloc_valid, alloc_addr, alloc_way, alloc_op, alloc_wb, alloc_victim,
    input  l2_req_ready, l2_resp_valid, l2_resp_id, fill_ready,
    output mshr_hit, mshr_full, l2_req_valid, l2_req_addr, l2_req_wb, l2_req_id,
    output fill_valid, fill_addr, fill_way, fill_op, fill_id
  );
endinterface

// File: rtl/cache_mshr_file_entry.sv
// cache_mshr_file_entry: one MSHR slot (alloc/req-accept/resp/fill-accept in; state flags + captured miss payload out)
module cache_mshr_file_entry import cache_mshr_file_pkg::*; #(
  parameter int LINE_AW = MSHR_LINE_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_alloc,
  input  logic [LINE_AW-1:0] i_addr,
  input  logic [LINE_AW-1:0] i_victim,
  input  logic [3:0]         i_way,
  input  logic [2:0]         i_op,
  input  logic               i_wb,
  input  logic               i_req_acc,
  input  logic               i_resp,
  input  logic               i_fill_acc,
  output logic               o_live,
  output logic               o_req,
  output logic               o_req_wb,
  output logic               o_wait,
  output logic               o_fill,
  output logic [LINE_AW-1:0] o_addr,
  output logic [LINE_AW-1:0] o_req_addr,
  output logic [3:0]         o_way,
  output logic [2:0]         o_op
);
  mshr_state_e        r_state, w_next;
  logic [LINE_AW-1:0] r_addr, r_victim;
  logic [3:0]         r_way;
  logic [2:0]         r_op;
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_victim <= '0;
      r_way    <= '0;
      r_op     <= '0;
    end else if (i_alloc) begin
      r_addr   <= i_addr;
      r_victim <= i_victim;
      r_way    <= i_way;
      r_op     <= i_op;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_alloc    ? (i_wb ? S_WB_REQ : S_RD_REQ) : S_IDLE;
      S_WB_REQ: w_next = i_req_acc  ? S_RD_REQ : S_WB_REQ;
      S_RD_REQ: w_next = i_req_acc  ? S_WAIT   : S_RD_REQ;
      S_WAIT:   w_next = i_resp     ? S_FILL   : S_WAIT;
      S_FILL:   w_next = i_fill_acc ? S_IDLE   : S_FILL;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    o_live     = r_state != S_IDLE;
    o_req_wb   = r_state == S_WB_REQ;
    o_req      = o_req_wb || r_state == S_RD_REQ;
    o_wait     = r_state == S_WAIT;
    o_fill     = r_state == S_FILL;
    o_req_addr = o_req_wb ? r_victim : r_addr;
  end
  assign o_addr = r_addr;
  assign o_way  = r_way;
  assign o_op   = r_op;
endmodule

// File: rtl/cache_mshr_file.sv
// cache_mshr_file: MSHR file (clk, rst, bus = slave side of cache_mshr_file_if) with free-slot encoder, frozen req/fill arbiters, hit OR-tree
module cache_mshr_file import cache_mshr_file_pkg::*; #(
  parameter int NUM_ENTRIES = MSHR_N,
  parameter int LINE_AW     = MSHR_LINE_AW,
  parameter int ID_W        = MSHR_ID_W
) (
  input logic clk,
  input logic rst,
  cache_mshr_file_if.slave bus
);
  logic [NUM_ENTRIES-1:0] w_live, w_req, w_req_wb, w_wait, w_fill, w_hit, w_dup;
  logic [NUM_ENTRIES-1:0] w_alloc, w_req_acc, w_resp, w_fill_acc;
  logic [LINE_AW-1:0]     w_addr [NUM_ENTRIES];
  logic [LINE_AW-1:0]     w_req_addr [NUM_ENTRIES];
  logic [3:0]             w_way [NUM_ENTRIES];
  logic [2:0]             w_op [NUM_ENTRIES];
  logic [ID_W-1:0]        w_free, w_req_pick, w_fill_pick, w_req_sel, w_fill_sel, r_req_sel, r_fill_sel;
  logic                   r_req_lock, r_fill_lock, w_full, w_alloc_ok, w_req_valid, w_fill_valid;
  genvar i;
  generate
    for (i = 0; i < NUM_ENTRIES; i++) begin : g_ent
      cache_mshr_file_entry #(.LINE_AW(LINE_AW)) u_ent (
        .clk(clk), .rst(rst), .i_alloc(w_alloc[i]), .i_addr(bus.alloc_addr), .i_victim(bus.alloc_victim),
        .i_way(bus.alloc_way), .i_op(bus.alloc_op), .i_wb(bus.alloc_wb), .i_req_acc(w_req_acc[i]),
        .i_resp(w_resp[i]), .i_fill_acc(w_fill_acc[i]), .o_live(w_live[i]), .o_req(w_req[i]),
        .o_req_wb(w_req_wb[i]), .o_wait(w_wait[i]), .o_fill(w_fill[i]), .o_addr(w_addr[i]),
        .o_req_addr(w_req_addr[i]), .o_way(w_way[i]), .o_op(w_op[i])
      );
      assign w_hit[i] = w_live[i] && w_addr[i] == bus.lookup_addr;
      assign w_dup[i] = w_live[i] && w_addr[i] == bus.alloc_addr;
    end
  endgenerate
  always_comb begin
    w_free      = '0;
    w_req_pick  = '0;
    w_fill_pick = '0;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      if (!w_live[k]) w_free      = ID_W'(k);
      if (w_req[k])   w_req_pick  = ID_W'(k);
      if (w_fill[k])  w_fill_pick = ID_W'(k);
    end
  end
  assign w_full       = &w_live;
  assign w_alloc_ok   = bus.alloc_valid && !w_full && is_alloc_op(bus.alloc_op);
  assign w_alloc      = NUM_ENTRIES'(w_alloc_ok) << w_free;
  assign w_resp       = NUM_ENTRIES'(bus.l2_resp_valid) << bus.l2_resp_id;
  // A granted-but-unaccepted request/fill keeps its slot even if a lower index becomes eligible.
  assign w_req_sel    = r_req_lock ? r_req_sel : w_req_pick;
  assign w_fill_sel   = r_fill_lock ? r_fill_sel : w_fill_pick;
  assign w_req_valid  = r_req_lock || |w_req;
  assign w_fill_valid = r_fill_lock || |w_fill;
  assign w_req_acc    = NUM_ENTRIES'(w_req_valid && bus.l2_req_ready) << w_req_sel;
  assign w_fill_acc   = NUM_ENTRIES'(w_fill_valid && bus.fill_ready) << w_fill_sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_lock  <= 1'b0;
      r_fill_lock <= 1'b0;
      r_req_sel   <= '0;
      r_fill_sel  <= '0;
    end else begin
      r_req_lock  <= w_req_valid && !bus.l2_req_ready;
      r_fill_lock <= w_fill_valid && !bus.fill_ready;
      r_req_sel   <= w_req_sel;
      r_fill_sel  <= w_fill_sel;
    end
  end
  assign bus.mshr_hit     = |w_hit;
  assign bus.mshr_full    = w_full;
  assign bus.l2_req_valid = w_req_valid;
  assign bus.l2_req_addr  = w_req_valid ? w_req_addr[w_req_sel] : '0;
  assign bus.l2_req_wb    = w_req_valid && w_req_wb[w_req_sel];
  assign bus.l2_req_id    = w_req_valid ? w_req_sel : '0;
  assign bus.fill_valid   = w_fill_valid;
  assign bus.fill_addr    = w_fill_valid ? w_addr[w_fill_sel] : '0;
  assign bus.fill_way     = w_fill_valid ? w_way[w_fill_sel] : '0;
  assign bus.fill_op      = w_fill_valid ? w_op[w_fill_sel] : '0;
  assign bus.fill_id      = w_fill_valid ? w_fill_sel : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.alloc_valid && w_full)) else $warning("mshr: alloc while full dropped");
      assert (!(w_alloc_ok && |w_dup)) else $warning("mshr: alloc to line already held");
      assert (!(bus.l2_resp_valid && !w_wait[bus.l2_resp_id])) else $warning("mshr: L2 resp to entry not waiting");
    end
  end
endmodule

// File: tb/tb_cache_mshr_file.sv
// tb_cache_mshr_file: directed scenario bench for cache_mshr_file
module tb_cache_mshr_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  cache_mshr_file_if bus ();
  cache_mshr_file dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic alloc(input logic [25:0] a, input logic [3:0] w, input logic [2:0] op, input logic wb, input logic [25:0] v);
    bus.alloc_valid = 1'b1; bus.alloc_addr = a; bus.alloc_way = w; bus.alloc_op = op; bus.alloc_wb = wb; bus.alloc_victim = v;
  endtask
  task automatic test_reset();
    bus.lookup_addr = '0; bus.alloc_valid = 0; bus.alloc_addr = '0; bus.alloc_way = '0; bus.alloc_op = '0;
    bus.alloc_wb = 0; bus.alloc_victim = '0; bus.l2_req_ready = 0; bus.l2_resp_valid = 0; bus.l2_resp_id = '0; bus.fill_ready = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0; #1;
    vecs++; if (bus.mshr_full !== 1'b0) begin errs++; $display("FAIL rst_full: got %b want 0", bus.mshr_full); end
    vecs++; if (bus.l2_req_valid !== 1'b0) begin errs++; $display("FAIL rst_req_valid: got %b want 0", bus.l2_req_valid); end
    vecs++; if (bus.fill_valid !== 1'b0) begin errs++; $display("FAIL rst_fill_valid: got %b want 0", bus.fill_valid); end
    vecs++; if (bus.mshr_hit !== 1'b0) begin errs++; $display("FAIL rst_hit: got %b want 0", bus.mshr_hit); end
    vecs++; if (bus.l2_req_addr !== 26'h0) begin errs++; $display("FAIL rst_req_addr: got %h want 0", bus.l2_req_addr); end
  endtask
  task automatic test_ld_miss();
    @(negedge clk); alloc(26'h100, 4'b0010, 3'd1, 0, 26'h0); bus.lookup_addr = 26'h100; bus.l2_req_ready = 1; #1;
    vecs++; if (bus.mshr_hit !== 1'b0) begin errs++; $display("FAIL ld_hit_alloc_cycle: got %b want 0", bus.mshr_hit); end
    @(negedge clk); bus.alloc_valid = 0; #1;
    vecs++; if (bus.l2_req_valid !== 1'b1) begin errs++; $display("FAIL ld_req_valid: got %b want 1", bus.l2_req_valid); end
    vecs++; if (bus.l2_req_addr !== 26'h100) begin errs++; $display("FAIL ld_req_addr: got %h want 100", bus.l2_req_addr); end
    vecs++; if (bus.l2_req_wb !== 1'b0) begin errs++; $display("FAIL ld_req_wb: got %b want 0", bus.l2_req_wb); end
    vecs++; if (bus.l2_req_id !== 2'd0) begin errs++; $display("FAIL ld_req_id: got %0d want 0", bus.l2_req_id); end
    vecs++; if (bus.mshr_hit !== 1'b1) begin errs++; $display("FAIL ld_hit: got %b want 1", bus.mshr_hit); end
    @(negedge clk); bus.l2_resp_valid = 1; bus.l2_resp_id = 2'd0; #1;
    vecs++; if (bus.l2_req_valid !== 1'b0) begin errs++; $display("FAIL ld_req_done: got %b want 0", bus.l2_req_valid); end
    @(negedge clk); bus.l2_resp_valid = 0; bus.fill_ready = 1; #1;
    vecs++; if (bus.fill_valid !== 1'b1) begin errs++; $display("FAIL ld_fill_valid: got %b want 1", bus.fill_valid); end
    vecs++; if (bus.fill_addr !== 26'h100) begin errs++; $display("FAIL ld_fill_addr: got %h want 100", bus.fill_addr); end
    vecs++; if (bus.fill_way !== 4'b0010) begin errs++; $display("FAIL ld_fill_way: got %b want 0010", bus.fill_way); end
    vecs++; if (bus.fill_op !== 3'd1) begin errs++; $display("FAIL ld_fill_op: got %0d want 1", bus.fill_op); end
    vecs++; if (bus.fill_id !== 2'd0) begin errs++; $display("FAIL ld_fill_id: got %0d want 0", bus.fill_id); end
    @(negedge clk); bus.fill_ready = 0; #1;
    vecs++; if (bus.fill_valid !== 1'b0) begin errs++; $display("FAIL ld_fill_done: got %b want 0", bus.fill_valid); end
    vecs++; if (bus.mshr_hit !== 1'b0) begin errs++; $display("FAIL ld_hit_freed: got %b want 0", bus.mshr_hit); end
  endtask
  task automatic test_st_writeback();
    @(negedge clk); alloc(26'h200, 4'b1000, 3'd2, 1, 26'h3F0); bus.l2_req_ready = 1;
    @(negedge clk); bus.alloc_valid = 0; #1;
    vecs++; if (bus.l2_req_addr !== 26'h3F0) begin errs++; $display("FAIL st_wb_addr: got %h want 3f0", bus.l2_req_addr); end
    vecs++; if (bus.l2_req_wb !== 1'b1) begin errs++; $display("FAIL st_wb_flag: got %b want 1", bus.l2_req_wb); end
    vecs++; if (bus.l2_req_id !== 2'd0) begin errs++; $display("FAIL st_wb_id: got %0d want 0", bus.l2_req_id); end
    @(negedge clk); #1;
    vecs++; if (bus.l2_req_valid !== 1'b1) begin errs++; $display("FAIL st_rd_valid: got %b want 1", bus.l2_req_valid); end
    vecs++; if (bus.l2_req_addr !== 26'h200) begin errs++; $display("FAIL st_rd_addr: got %h want 200", bus.l2_req_addr); end
    vecs++; if (bus.l2_req_wb !== 1'b0) begin errs++; $display("FAIL st_rd_wb: got %b want 0", bus.l2_req_wb); end
    @(negedge clk); bus.l2_resp_valid = 1; bus.l2_resp_id = 2'd0; #1;
    vecs++; if (bus.l2_req_valid !== 1'b0) begin errs++; $display("FAIL st_req_done: got %b want 0", bus.l2_req_valid); end
    @(negedge clk); bus.l2_resp_valid = 0; bus.fill_ready = 1; #1;
    vecs++; if (bus.fill_op !== 3'd2) begin errs++; $display("FAIL st_fill_op: got %0d want 2", bus.fill_op); end
    vecs++; if (bus.fill_way !== 4'b1000) begin errs++; $display("FAIL st_fill_way: got %b want 1000", bus.fill_way); end
    @(negedge clk); bus.fill_ready = 0; #1;
    vecs++; if (bus.fill_valid !== 1'b0) begin errs++; $display("FAIL st_fill_done: got %b want 0", bus.fill_valid); end
  endtask
  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); alloc(26'h100 + 26'(k), 4'(1 << k), 3'd1, 0, 26'h0); bus.l2_req_ready = 0; #1;
      vecs++; if (bus.mshr_full !== 1'b0) begin errs++; $display("FAIL full_early%0d: got %b want 0", k, bus.mshr_full); end
    end
    @(negedge clk); alloc(26'h104, 4'b0001, 3'd1, 0, 26'h0); bus.lookup_addr = 26'h100; #1;
    vecs++; if (bus.mshr_full !== 1'b1) begin errs++; $display("FAIL full_set: got %b want 1", bus.mshr_full); end
    vecs++; if (bus.mshr_hit !== 1'b1) begin errs++; $display("FAIL full_hit100: got %b want 1", bus.mshr_hit); end
    @(negedge clk); bus.alloc_valid = 0; bus.lookup_addr = 26'h104; #1;
    vecs++; if (bus.mshr_hit !== 1'b0) begin errs++; $display("FAIL full_drop_hit: got %b want 0", bus.mshr_hit); end
    vecs++; if (bus.mshr_full !== 1'b1) begin errs++; $display("FAIL full_hold: got %b want 1", bus.mshr_full); end
  endtask
  task automatic test_req_stall();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      vecs++; if (bus.l2_req_valid !== 1'b1) begin errs++; $display("FAIL stall_valid%0d: got %b want 1", k, bus.l2_req_valid); end
      vecs++; if (bus.l2_req_addr !== 26'h100) begin errs++; $display("FAIL stall_addr%0d: got %h want 100", k, bus.l2_req_addr); end
      vecs++; if (bus.l2_req_id !== 2'd0) begin errs++; $display("FAIL stall_id%0d: got %0d want 0", k, bus.l2_req_id); end
      vecs++; if (bus.l2_req_wb !== 1'b0) begin errs++; $display("FAIL stall_wb%0d: got %b want 0", k, bus.l2_req_wb); end
    end
    @(negedge clk); bus.l2_req_ready = 1; #1;
    vecs++; if (bus.l2_req_id !== 2'd0) begin errs++; $display("FAIL stall_accept_id: got %0d want 0", bus.l2_req_id); end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      vecs++; if (bus.l2_req_id !== 2'(k)) begin errs++; $display("FAIL next_req_id%0d: got %0d want %0d", k, bus.l2_req_id, k); end
      vecs++; if (bus.l2_req_addr !== 26'h100 + 26'(k)) begin errs++; $display("FAIL next_req_addr%0d: got %h want %h", k, bus.l2_req_addr, 26'h100 + 26'(k)); end
    end
    @(negedge clk); bus.l2_req_ready = 0; #1;
    vecs++; if (bus.l2_req_valid !== 1'b0) begin errs++; $display("FAIL req_drained: got %b want 0", bus.l2_req_valid); end
  endtask
  task automatic test_ooo_fill();
    bus.fill_ready = 0; bus.l2_resp_valid = 1; bus.l2_resp_id = 2'd2;
    @(negedge clk); bus.l2_resp_id = 2'd0; #1;
    vecs++; if (bus.fill_id !== 2'd2) begin errs++; $display("FAIL ooo_first_id: got %0d want 2", bus.fill_id); end
    @(negedge clk); bus.l2_resp_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      vecs++; if (bus.fill_id !== 2'd2) begin errs++; $display("FAIL ooo_hold_id%0d: got %0d want 2", k, bus.fill_id); end
      vecs++; if (bus.fill_addr !== 26'h102) begin errs++; $display("FAIL ooo_hold_addr%0d: got %h want 102", k, bus.fill_addr); end
      @(negedge clk);
    end
    bus.fill_ready = 1; #1;
    vecs++; if (bus.fill_id !== 2'd2) begin errs++; $display("FAIL ooo_accept_id: got %0d want 2", bus.fill_id); end
    @(negedge clk); #1;
    vecs++; if (bus.fill_id !== 2'd0) begin errs++; $display("FAIL ooo_second_id: got %0d want 0", bus.fill_id); end
    vecs++; if (bus.fill_addr !== 26'h100) begin errs++; $display("FAIL ooo_second_addr: got %h want 100", bus.fill_addr); end
    @(negedge clk); bus.fill_ready = 0; bus.l2_resp_valid = 1; bus.l2_resp_id = 2'd1; #1;
    vecs++; if (bus.fill_valid !== 1'b0) begin errs++; $display("FAIL ooo_gap: got %b want 0", bus.fill_valid); end
    @(negedge clk); bus.l2_resp_id = 2'd3; bus.fill_ready = 1; #1;
    vecs++; if (bus.fill_id !== 2'd1) begin errs++; $display("FAIL ooo_id1: got %0d want 1", bus.fill_id); end
    @(negedge clk); bus.l2_resp_valid = 0; #1;
    vecs++; if (bus.fill_id !== 2'd3) begin errs++; $display("FAIL ooo_id3: got %0d want 3", bus.fill_id); end
    @(negedge clk); bus.fill_ready = 0; bus.lookup_addr = 26'h103; #1;
    vecs++; if (bus.fill_valid !== 1'b0) begin errs++; $display("FAIL ooo_empty_fill: got %b want 0", bus.fill_valid); end
    vecs++; if (bus.mshr_full !== 1'b0) begin errs++; $display("FAIL ooo_empty_full: got %b want 0", bus.mshr_full); end
    vecs++; if (bus.mshr_hit !== 1'b0) begin errs++; $display("FAIL ooo_empty_hit: got %b want 0", bus.mshr_hit); end
  endtask
  task automatic test_reset_mid();
    @(negedge clk); alloc(26'h300, 4'b0001, 3'd1, 0, 26'h0); bus.l2_req_ready = 1;
    @(negedge clk); alloc(26'h301, 4'b0010, 3'd2, 0, 26'h0);
    @(negedge clk); bus.alloc_valid = 0;
    @(negedge clk); bus.l2_req_ready = 0; bus.l2_resp_valid = 1; bus.l2_resp_id = 2'd0;
    @(negedge clk); bus.l2_resp_valid = 0; #1;
    vecs++; if (bus.fill_valid !== 1'b1) begin errs++; $display("FAIL mid_fill_pre: got %b want 1", bus.fill_valid); end
    rst = 1;
    @(negedge clk); rst = 0; bus.lookup_addr = 26'h300; bus.l2_resp_valid = 1; bus.l2_resp_id = 2'd1; #1;
    vecs++; if (bus.fill_valid !== 1'b0) begin errs++; $display("FAIL mid_fill: got %b want 0", bus.fill_valid); end
    vecs++; if (bus.fill_id !== 2'd0 || bus.fill_way !== 4'd0 || bus.fill_op !== 3'd0) begin errs++; $display("FAIL mid_fill_bus: got %0d/%b/%0d want 0/0000/0", bus.fill_id, bus.fill_way, bus.fill_op); end
    vecs++; if (bus.l2_req_valid !== 1'b0 || bus.l2_req_wb !== 1'b0) begin errs++; $display("FAIL mid_req: got %b/%b want 0/0", bus.l2_req_valid, bus.l2_req_wb); end
    vecs++; if (bus.mshr_hit !== 1'b0) begin errs++; $display("FAIL mid_hit: got %b want 0", bus.mshr_hit); end
    vecs++; if (bus.mshr_full !== 1'b0) begin errs++; $display("FAIL mid_full: got %b want 0", bus.mshr_full); end
    @(negedge clk); bus.l2_resp_valid = 0; bus.lookup_addr = 26'h301; alloc(26'h305, 4'b0001, 3'd0, 0, 26'h0); #1;
    vecs++; if (bus.fill_valid !== 1'b0) begin errs++; $display("FAIL mid_stale_resp: got %b want 0", bus.fill_valid); end
    vecs++; if (bus.mshr_hit !== 1'b0) begin errs++; $display("FAIL mid_hit301: got %b want 0", bus.mshr_hit); end
    @(negedge clk); bus.alloc_valid = 0; bus.lookup_addr = 26'h305; #1;
    vecs++; if (bus.l2_req_valid !== 1'b0) begin errs++; $display("FAIL noop_req: got %b want 0", bus.l2_req_valid); end
    vecs++; if (bus.mshr_hit !== 1'b0) begin errs++; $display("FAIL noop_hit: got %b want 0", bus.mshr_hit); end
  endtask
  initial begin
    test_reset();
    test_ld_miss();
    test_st_writeback();
    test_full();
    test_req_stall();
    test_ooo_fill();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
